// File: rtl/prbs_multilane_checker.sv
// Multi-lane self-synchronising PRBS7 (x^7+x^6+1) checker with per-lane lock FSM and error counters.
// Latency: one cycle from a sampled lane word to lock/err/count/loss outputs.
// Backpressure: none; words are consumed when data_valid_i is high, and all state holds otherwise.
module prbs_multilane_checker #(
  parameter int NUM_LANES     = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int REV_BITS      = 1,
  parameter int ERR_CNT_WIDTH = 16,
  parameter int LOCK_THRESH   = 16,
  parameter int LOSS_THRESH   = 4
) (
  input  logic                               clk_i,
  input  logic                               resetn_i,
  input  logic                               prbs_en_i,
  input  logic                               clear_i,
  input  logic                               data_valid_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]    data_in_i,
  output logic [NUM_LANES-1:0]               lock_o,
  output logic                               all_lock_o,
  output logic [NUM_LANES-1:0]               err_o,
  output logic                               prbs_chk_error_o,
  output logic [NUM_LANES-1:0]               loss_of_lock_o,
  output logic [NUM_LANES*ERR_CNT_WIDTH-1:0] err_cnt_o
);

  localparam logic [1:0] ST_SEED   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int PC_W  = $clog2(DATA_WIDTH + 1);
  // One extra bit over the wider operand so the saturation test sees the true sum.
  localparam int SUM_W = ((ERR_CNT_WIDTH > PC_W) ? ERR_CNT_WIDTH : PC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({ERR_CNT_WIDTH{1'b1}});
  localparam logic [7:0] LOCK_T = 8'(LOCK_THRESH);
  localparam logic [3:0] LOSS_T = 4'(LOSS_THRESH);

  logic [NUM_LANES-1:0][1:0]               state_q,   state_d;
  logic [NUM_LANES-1:0][6:0]               lfsr_q,    lfsr_d;
  logic [NUM_LANES-1:0][7:0]               good_q,    good_d;
  logic [NUM_LANES-1:0][3:0]               bad_q,     bad_d;
  logic [NUM_LANES-1:0][ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [NUM_LANES-1:0]                    lol_q,     lol_d;
  logic [NUM_LANES-1:0]                    err_q,     err_d;
  logic [NUM_LANES-1:0]                    lock_q,    lock_d;
  logic                                    all_lock_q, all_lock_d;
  logic                                    chk_err_q,  chk_err_d;

  // Expected word: continue the sequence from the 7-bit history, MSB first in time.
  // Bit 6 of the history is the oldest bit, bit 0 the newest.
  function automatic logic [DATA_WIDTH-1:0] prbs_word(input logic [6:0] seed);
    logic [6:0]            s;
    logic [DATA_WIDTH-1:0] w;
    logic                  b;
    s = seed;
    w = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      b    = s[6] ^ s[5];
      w[i] = b;
      s    = {s[5:0], b};
    end
    return w;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] bit_reverse(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      r[i] = v[DATA_WIDTH-1-i];
    end
    return r;
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  // State register: every flop, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q    <= '0;
      lfsr_q     <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      err_cnt_q  <= '0;
      lol_q      <= '0;
      err_q      <= '0;
      lock_q     <= '0;
      all_lock_q <= 1'b0;
      chk_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      err_cnt_q  <= err_cnt_d;
      lol_q      <= lol_d;
      err_q      <= err_d;
      lock_q     <= lock_d;
      all_lock_q <= all_lock_d;
      chk_err_q  <= chk_err_d;
    end
  end

  // Next state and per-lane datapath: seeding, verify/lock counting, error accounting.
  always_comb begin
    logic [DATA_WIDTH-1:0]    word;
    logic [DATA_WIDTH-1:0]    expw;
    logic [PC_W-1:0]          pc;
    logic [SUM_W-1:0]         sum;
    logic [ERR_CNT_WIDTH-1:0] cnt_sat;
    logic [7:0]               good_inc;
    logic [3:0]               bad_inc;
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    good_d    = good_q;
    bad_d     = bad_q;
    err_cnt_d = err_cnt_q;
    lol_d     = lol_q;
    err_d     = '0;
    word      = '0;
    expw      = '0;
    pc        = '0;
    sum       = '0;
    cnt_sat   = '0;
    good_inc  = '0;
    bad_inc   = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      word = data_in_i[n*DATA_WIDTH +: DATA_WIDTH];
      if (REV_BITS != 0) begin
        word = bit_reverse(word);
      end
      expw     = prbs_word(lfsr_q[n]);
      pc       = popcount(word ^ expw);
      sum      = SUM_W'(err_cnt_q[n]) + SUM_W'(pc);
      cnt_sat  = (sum > CNT_MAX) ? {ERR_CNT_WIDTH{1'b1}} : sum[ERR_CNT_WIDTH-1:0];
      good_inc = good_q[n] + 8'd1;
      bad_inc  = bad_q[n] + 4'd1;

      if (!prbs_en_i) begin
        state_d[n] = ST_SEED;
        good_d[n]  = '0;
        bad_d[n]   = '0;
      end else if (data_valid_i) begin
        case (state_q[n])
          ST_VERIFY: begin
            if (pc == '0) begin
              good_d[n] = good_inc;
              lfsr_d[n] = expw[6:0];
              if (good_inc == LOCK_T) begin
                state_d[n] = ST_LOCKED;
                bad_d[n]   = '0;
              end
            end else begin
              good_d[n] = '0;
              lfsr_d[n] = word[6:0];
            end
          end
          ST_LOCKED: begin
            // Free-running: received data never reseeds a locked lane.
            lfsr_d[n] = expw[6:0];
            if (pc != '0) begin
              err_cnt_d[n] = cnt_sat;
              err_d[n]     = 1'b1;
              bad_d[n]     = bad_inc;
              if (bad_inc == LOSS_T) begin
                state_d[n] = ST_SEED;
                lol_d[n]   = 1'b1;
                good_d[n]  = '0;
                bad_d[n]   = '0;
              end
            end else begin
              bad_d[n] = '0;
            end
          end
          default: begin
            lfsr_d[n]  = word[6:0];
            good_d[n]  = '0;
            bad_d[n]   = '0;
            state_d[n] = ST_VERIFY;
          end
        endcase
      end

      // Clear wins over this cycle's increment or loss event; lock state is untouched.
      if (clear_i) begin
        err_cnt_d[n] = '0;
        lol_d[n]     = 1'b0;
      end
    end
  end

  // Registered outputs derived from next-state values so the summaries align with lock_o/err_o.
  always_comb begin
    lock_d = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      lock_d[n] = (state_d[n] == ST_LOCKED);
    end
    all_lock_d = &lock_d;
    chk_err_d  = |err_d;
  end

  assign lock_o           = lock_q;
  assign all_lock_o       = all_lock_q;
  assign err_o            = err_q;
  assign prbs_chk_error_o = chk_err_q;
  assign loss_of_lock_o   = lol_q;
  assign err_cnt_o        = err_cnt_q;

endmodule

// File: tb/tb_prbs_multilane_checker.sv
// Bench for prbs_multilane_checker: three instances (default, no bit reversal, 4-bit counters)
// share one stimulus; a bit-level reference model predicts every output each cycle.
// Directed phases cover lock timing, errors, loss/relock, gaps, saturation, clear and reset.
module tb_prbs_multilane_checker;
  localparam int NL = 4;
  localparam int DW = 8;
  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, en, clr, vld;
  logic [NL*DW-1:0] data;

  logic [NL-1:0]    lock_a, err_a, lol_a, lock_b, err_b, lol_b, lock_c, err_c, lol_c;
  logic             all_a, chk_a, all_b, chk_b, all_c, chk_c;
  logic [NL*16-1:0] cnt_a, cnt_b;
  logic [NL*4-1:0]  cnt_c;

  prbs_multilane_checker #(.NUM_LANES(NL), .DATA_WIDTH(DW), .REV_BITS(1), .ERR_CNT_WIDTH(16),
                           .LOCK_THRESH(16), .LOSS_THRESH(4)) u_a (
    .clk_i(clk), .resetn_i(rst_n), .prbs_en_i(en), .clear_i(clr), .data_valid_i(vld),
    .data_in_i(data), .lock_o(lock_a), .all_lock_o(all_a), .err_o(err_a),
    .prbs_chk_error_o(chk_a), .loss_of_lock_o(lol_a), .err_cnt_o(cnt_a));

  prbs_multilane_checker #(.NUM_LANES(NL), .DATA_WIDTH(DW), .REV_BITS(0), .ERR_CNT_WIDTH(16),
                           .LOCK_THRESH(16), .LOSS_THRESH(4)) u_b (
    .clk_i(clk), .resetn_i(rst_n), .prbs_en_i(en), .clear_i(clr), .data_valid_i(vld),
    .data_in_i(data), .lock_o(lock_b), .all_lock_o(all_b), .err_o(err_b),
    .prbs_chk_error_o(chk_b), .loss_of_lock_o(lol_b), .err_cnt_o(cnt_b));

  prbs_multilane_checker #(.NUM_LANES(NL), .DATA_WIDTH(DW), .REV_BITS(1), .ERR_CNT_WIDTH(4),
                           .LOCK_THRESH(16), .LOSS_THRESH(4)) u_c (
    .clk_i(clk), .resetn_i(rst_n), .prbs_en_i(en), .clear_i(clr), .data_valid_i(vld),
    .data_in_i(data), .lock_o(lock_c), .all_lock_o(all_c), .err_o(err_c),
    .prbs_chk_error_o(chk_c), .loss_of_lock_o(lol_c), .err_cnt_o(cnt_c));

  // Reference model: per instance and lane, state 0=seed 1=verify 2=locked.
  // hist holds the last 7 sequence bits, hist[0] oldest.
  int   m_rev [ND] = '{1, 0, 1};
  int   m_w   [ND] = '{16, 16, 4};
  int   m_st  [ND][NL];
  int   m_good[ND][NL];
  int   m_bad [ND][NL];
  int   m_cnt [ND][NL];
  bit   m_lol [ND][NL];
  bit   m_err [ND][NL];
  bit [6:0] m_hist[ND][NL];

  bit seq[127];
  int pos[NL];
  int tests = 0;
  int fails = 0;
  bit saw_chk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < ND; d++) begin
      for (int l = 0; l < NL; l++) begin
        bit [DW-1:0] rx, ex;
        bit [6:0]    h;
        int          pc, maxc;
        if (!rst_n) begin
          m_st[d][l] = 0; m_good[d][l] = 0; m_bad[d][l] = 0; m_cnt[d][l] = 0;
          m_lol[d][l] = 0; m_err[d][l] = 0; m_hist[d][l] = '0;
        end else begin
          m_err[d][l] = 0;
          if (!en) begin
            m_st[d][l] = 0; m_good[d][l] = 0; m_bad[d][l] = 0;
          end else if (vld) begin
            // rx[t] is the bit at time position t within the word
            for (int t = 0; t < DW; t++)
              rx[t] = (m_rev[d] != 0) ? data[l*DW + t] : data[l*DW + DW - 1 - t];
            h  = m_hist[d][l];
            pc = 0;
            for (int t = 0; t < DW; t++) begin
              ex[t] = h[0] ^ h[1];
              h     = {ex[t], h[6:1]};
              if (rx[t] != ex[t]) pc++;
            end
            maxc = (1 << m_w[d]) - 1;
            if (m_st[d][l] == 0) begin
              for (int k = 0; k < 7; k++) m_hist[d][l][k] = rx[DW-7+k];
              m_good[d][l] = 0;
              m_st[d][l]   = 1;
            end else if (m_st[d][l] == 1) begin
              if (pc == 0) begin
                m_good[d][l]++;
                m_hist[d][l] = h;
                if (m_good[d][l] == 16) begin
                  m_st[d][l]  = 2;
                  m_bad[d][l] = 0;
                end
              end else begin
                for (int k = 0; k < 7; k++) m_hist[d][l][k] = rx[DW-7+k];
                m_good[d][l] = 0;
              end
            end else begin
              m_hist[d][l] = h;
              if (pc != 0) begin
                m_cnt[d][l] = (m_cnt[d][l] + pc > maxc) ? maxc : m_cnt[d][l] + pc;
                m_err[d][l] = 1;
                m_bad[d][l]++;
                if (m_bad[d][l] == 4) begin
                  m_st[d][l] = 0; m_lol[d][l] = 1; m_bad[d][l] = 0; m_good[d][l] = 0;
                end
              end else begin
                m_bad[d][l] = 0;
              end
            end
          end
          if (clr) begin
            m_cnt[d][l] = 0;
            m_lol[d][l] = 0;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < ND; d++) begin
      logic [NL-1:0] ol, oe, oo, el, ee, eo;
      logic          oal, och;
      logic [63:0]   oc, ec;
      case (d)
        0:       begin ol = lock_a; oe = err_a; oo = lol_a; oal = all_a; och = chk_a; oc = 64'(cnt_a); end
        1:       begin ol = lock_b; oe = err_b; oo = lol_b; oal = all_b; och = chk_b; oc = 64'(cnt_b); end
        default: begin ol = lock_c; oe = err_c; oo = lol_c; oal = all_c; och = chk_c; oc = 64'(cnt_c); end
      endcase
      ec = '0;
      for (int l = 0; l < NL; l++) begin
        el[l] = (m_st[d][l] == 2);
        ee[l] = m_err[d][l];
        eo[l] = m_lol[d][l];
        if (d == 2) ec[l*4 +: 4]   = 4'(m_cnt[d][l]);
        else        ec[l*16 +: 16] = 16'(m_cnt[d][l]);
      end
      chk($sformatf("d%0d_lock", d),     64'(ol),  64'(el));
      chk($sformatf("d%0d_err", d),      64'(oe),  64'(ee));
      chk($sformatf("d%0d_loss", d),     64'(oo),  64'(eo));
      chk($sformatf("d%0d_all_lock", d), 64'(oal), 64'(&el));
      chk($sformatf("d%0d_chk_err", d),  64'(och), 64'(|ee));
      chk($sformatf("d%0d_err_cnt", d),  oc,       ec);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    compare_all();
    saw_chk = saw_chk | chk_a;
  endtask

  // Drive one cycle; a valid word is the next clean PRBS word per lane XOR the error mask.
  task automatic send(input bit v, input logic [NL*DW-1:0] xm);
    logic [NL*DW-1:0] w;
    for (int l = 0; l < NL; l++)
      for (int t = 0; t < DW; t++)
        w[l*DW + t] = seq[(pos[l] + t) % 127];
    if (v) begin
      data = w ^ xm;
      for (int l = 0; l < NL; l++) pos[l] = (pos[l] + DW) % 127;
    end else begin
      data = $urandom;
    end
    vld = v;
    tick();
  endtask

  initial begin
    logic [NL*DW-1:0] m;
    int burst_lane, burst_left;

    for (int i = 0; i < 7; i++) seq[i] = 1'b1;
    for (int i = 7; i < 127; i++) seq[i] = seq[i-7] ^ seq[i-6];
    for (int l = 0; l < NL; l++) pos[l] = l * 31 + int'($urandom_range(0, 25));

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; vld = 1'b0; data = '0; saw_chk = 1'b0;
    tick();
    tick();
    chk("reset_lock", 64'(lock_a), 64'h0);
    chk("reset_cnt",  64'(cnt_a),  64'h0);

    // Clean lock on all lanes; REV_BITS=0 instance must not lock on the same stream.
    rst_n = 1'b1; en = 1'b1; saw_chk = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      send(1'b1, '0);
      if (k == 16) chk("lock_after_16", 64'(lock_a), 64'h0);
      if (k == 17) begin
        chk("lock_after_17", 64'(lock_a), 64'hF);
        chk("all_lock_17",   64'(all_a),  64'h1);
      end
    end
    chk("clean_no_chk_err", 64'(saw_chk), 64'h0);
    chk("clean_cnt_zero",   64'(cnt_a),   64'h0);
    chk("norev_no_lock",    64'(lock_b),  64'h0);

    // Single-bit error on lane 2.
    m = '0;
    m[16 + $urandom_range(0, 7)] = 1'b1;
    send(1'b1, m);
    chk("sbe_err_pulse", 64'(err_a), 64'h4);
    chk("sbe_cnt2",      64'(cnt_a[47:32]), 64'd1);
    chk("sbe_lock",      64'(lock_a), 64'hF);
    send(1'b1, '0);
    chk("sbe_err_gone",  64'(err_a), 64'h0);
    chk("sbe_others",    64'({cnt_a[63:48], cnt_a[31:0]}), 64'h0);

    // Four inverted lane-1 words drop lock; 17 clean words relock; loss stays sticky.
    for (int k = 1; k <= 4; k++) begin
      send(1'b1, 32'h0000FF00);
      if (k == 3) chk("loss_still_locked", 64'(lock_a[1]), 64'h1);
    end
    chk("loss_lock1", 64'(lock_a[1]), 64'h0);
    chk("loss_flag1", 64'(lol_a[1]),  64'h1);
    chk("loss_cnt1",  64'(cnt_a[31:16]), 64'd32);
    for (int k = 1; k <= 17; k++) begin
      send(1'b1, '0);
      if (k == 16) chk("relock_16", 64'(lock_a[1]), 64'h0);
    end
    chk("relock_17",   64'(lock_a[1]), 64'h1);
    chk("loss_sticky", 64'(lol_a[1]),  64'h1);
    clr = 1'b1;
    send(1'b1, '0);
    clr = 1'b0;
    chk("clear_loss", 64'(lol_a), 64'h0);
    chk("clear_cnt",  64'(cnt_a), 64'h0);

    // Valid toggling every cycle: lock after 17 valid words, no false loss.
    rst_n = 1'b0;
    send(1'b0, '0);
    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      send(1'b1, '0);
      chk($sformatf("gap_lock_v%0d", k), 64'(lock_a), (k == 17) ? 64'hF : 64'h0);
      send(1'b0, '0);
    end
    chk("gap_lock_hold", 64'(lock_a), 64'hF);
    chk("gap_no_loss",   64'(lol_a),  64'h0);

    // Saturation in the 4-bit instance, then clear in the same cycle as an error word.
    send(1'b1, '1);
    chk("sat_first", 64'(cnt_c), 64'h8888);
    send(1'b1, '1);
    chk("sat_held",  64'(cnt_c), 64'hFFFF);
    chk("sat_wide",  64'(cnt_a), 64'h0010_0010_0010_0010);
    clr = 1'b1;
    send(1'b1, 32'h000000FF);
    clr = 1'b0;
    chk("clear_prio_c", 64'(cnt_c), 64'h0);
    chk("clear_prio_a", 64'(cnt_a), 64'h0);
    send(1'b1, '0);

    // Randomised traffic: gaps, sparse errors, bursts, clears and enable drops.
    burst_left = 0;
    burst_lane = 0;
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 99) >= 2);
      clr = ($urandom_range(0, 99) < 3);
      m = '0;
      for (int l = 0; l < NL; l++)
        if ($urandom_range(0, 99) < 8) m[l*DW +: DW] = 8'($urandom_range(1, 255));
      if (burst_left == 0 && $urandom_range(0, 99) < 3) begin
        burst_left = 5;
        burst_lane = int'($urandom_range(0, NL - 1));
      end
      if (burst_left > 0) begin
        m[burst_lane*DW +: DW] = 8'hFF;
        burst_left--;
      end
      send($urandom_range(0, 99) < 70, m);
    end

    // Relock, then a one-cycle reset while locked clears everything on that edge.
    en = 1'b1; clr = 1'b0;
    for (int k = 0; k < 24; k++) send(1'b1, '0);
    chk("pre_reset_lock_a", 64'(lock_a), 64'hF);
    chk("pre_reset_lock_c", 64'(lock_c), 64'hF);
    rst_n = 1'b0;
    send(1'b1, 32'h01010101);
    rst_n = 1'b1;
    chk("rst_lock",     64'(lock_a), 64'h0);
    chk("rst_all_lock", 64'(all_a),  64'h0);
    chk("rst_err",      64'(err_a),  64'h0);
    chk("rst_loss",     64'(lol_a),  64'h0);
    chk("rst_cnt_a",    64'(cnt_a),  64'h0);
    chk("rst_cnt_c",    64'(cnt_c),  64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
